cbb_rs_forward: RTL and testbench

Forward register slice for a single valid/ready stream. It registers the forward path (`valid` and `data`) to break long combinational paths between a producer and a consumer. The backward `ready` path stays combinational. It sits between any upstream master (slave-side port `slv_*`) and downstream slave (master-side port `mst_*`), and sustains one transfer per clock with one cycle of latency.

---
 rtl/cbb_rs_forward.sv | 51 +++++
 tb/tb_cbb_rs_forward.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cbb_rs_forward.sv
// cbb_rs_forward: forward register slice for one valid/ready stream.
// Registers valid and data toward the consumer. The ready path back to the
// producer stays combinational, so the slice sustains one beat per clock
// with one cycle of latency and a capacity of one beat.
module cbb_rs_forward #(
  parameter int P_DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    slv_i_valid,
  input  logic [P_DATA_WIDTH-1:0] slv_i_data,
  output logic                    slv_o_ready,
  output logic                    mst_o_valid,
  output logic [P_DATA_WIDTH-1:0] mst_o_data,
  input  logic                    mst_i_ready
);

  logic                    valid_q, valid_d;
  logic [P_DATA_WIDTH-1:0] data_q,  data_d;
  logic                    load;

  // Accept when the stage is empty or is being drained this edge; never in reset.
  assign slv_o_ready = ~i_rstn & (~valid_q | mst_i_ready);
  assign load        = slv_i_valid & slv_o_ready;

  // Next-state: refill or drain on ready, capture payload only on a real transfer.
  always_comb begin
    // NOTE: defaults first so every path assigns valid_d/data_d and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    if (slv_o_ready) valid_d = slv_i_valid;
    if (load)        data_d  = slv_i_data;
  end

  // Storage stage; reset is active-high on i_rstn and acts without a clock edge.
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      valid_q <= 1'b0;
      // NOTE: the payload register is reset too, so mst_o_data reads 0 out of reset.
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign mst_o_valid = valid_q;
  assign mst_o_data  = data_q;

endmodule

// File: tb/tb_cbb_rs_forward.sv
// tb_cbb_rs_forward: directed + randomized-backpressure bench with a scoreboard.
// Upstream transfers push into a queue; downstream transfers pop and compare.
module tb_cbb_rs_forward;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic         slv_i_valid;
  logic [W-1:0] slv_i_data;
  logic         slv_o_ready;
  logic         mst_o_valid;
  logic [W-1:0] mst_o_data;
  logic         mst_i_ready;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [W-1:0] sb[$];

  cbb_rs_forward #(.P_DATA_WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .slv_i_valid (slv_i_valid),
    .slv_i_data  (slv_i_data),
    .slv_o_ready (slv_o_ready),
    .mst_o_valid (mst_o_valid),
    .mst_o_data  (mst_o_data),
    .mst_i_ready (mst_i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard monitor: sample at the active edge before the DUT updates.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic [W-1:0] exp_beat;

  always @(posedge i_rstn) begin
    sb.delete();
    prev_stall = 1'b0;
  end

  always @(posedge i_clk) begin
    if (i_rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", {31'b0, mst_o_valid}, 32'd1);
        check("stall_data_hold", mst_o_data, prev_data);
      end
      if (mst_o_valid && mst_i_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", mst_o_data, 32'hXXXX_XXXX);
        end else begin
          exp_beat = sb.pop_front();
          check("sb_order", mst_o_data, exp_beat);
        end
        n_out++;
      end
      if (slv_i_valid && slv_o_ready) sb.push_back(slv_i_data);
      prev_stall = mst_o_valid && !mst_i_ready;
      prev_data  = mst_o_data;
    end
  end

  initial begin
    int sent, gap, phase, budget, out_mark;
    logic pending;

    // Reset with busy inputs.
    i_rstn = 1'b1; slv_i_valid = 1'b1; slv_i_data = 32'hA5A5_A5A5; mst_i_ready = 1'b1;
    step(); step(); step();
    check("rst_valid", {31'b0, mst_o_valid}, 32'd0);
    check("rst_data", mst_o_data, 32'd0);
    check("rst_ready", {31'b0, slv_o_ready}, 32'd0);

    i_rstn = 1'b0; slv_i_valid = 1'b0; mst_i_ready = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, slv_o_ready}, 32'd1);

    // Single beat with downstream stalled.
    slv_i_valid = 1'b1; slv_i_data = 32'hDEAD_BEEF;
    step();
    slv_i_valid = 1'b0;
    check("single_valid", {31'b0, mst_o_valid}, 32'd1);
    check("single_data", mst_o_data, 32'hDEAD_BEEF);
    check("single_ready_low", {31'b0, slv_o_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'b0, mst_o_valid}, 32'd1);
      check("stall_data", mst_o_data, 32'hDEAD_BEEF);
      check("stall_ready", {31'b0, slv_o_ready}, 32'd0);
    end
    mst_i_ready = 1'b1;
    #1;
    check("ready_comb", {31'b0, slv_o_ready}, 32'd1);
    step();
    check("drain_valid", {31'b0, mst_o_valid}, 32'd0);

    // Streaming at full rate.
    for (int i = 1; i <= 20; i++) begin
      slv_i_valid = 1'b1; slv_i_data = W'(i);
      step();
      check("stream_valid", {31'b0, mst_o_valid}, 32'd1);
      check("stream_data", mst_o_data, W'(i));
      check("stream_ready", {31'b0, slv_o_ready}, 32'd1);
    end
    slv_i_valid = 1'b0;
    step();
    check("stream_end_valid", {31'b0, mst_o_valid}, 32'd0);

    // Full stage, simultaneous drain and refill.
    mst_i_ready = 1'b0; slv_i_valid = 1'b1; slv_i_data = 32'h11;
    step();
    check("fill_11", mst_o_data, 32'h11);
    out_mark = n_out;
    mst_i_ready = 1'b1; slv_i_data = 32'h22;
    step();
    slv_i_valid = 1'b0;
    check("simul_valid", {31'b0, mst_o_valid}, 32'd1);
    check("simul_data", mst_o_data, 32'h22);
    check("simul_consumed_once", W'(n_out - out_mark), 32'd1);
    step();
    check("simul_drain_count", W'(n_out - out_mark), 32'd2);
    check("simul_drain_valid", {31'b0, mst_o_valid}, 32'd0);

    // Random gaps and backpressure.
    out_mark = n_out; sent = 0; pending = 1'b0; gap = 0; phase = 1; budget = 3000;
    while (budget > 0 && !(sent == 20 && !pending && n_out - out_mark == 20)) begin
      if (--phase == 0) begin
        mst_i_ready = ~mst_i_ready;
        phase = $urandom_range(1, 10);
      end
      if (!pending && sent < 20) begin
        if (gap == 0) begin
          pending = 1'b1; slv_i_valid = 1'b1; slv_i_data = $urandom; sent++;
        end else begin
          gap--;
        end
      end
      #1;
      if (pending && slv_o_ready) begin
        step();
        pending = 1'b0; slv_i_valid = 1'b0; slv_i_data = $urandom;
        gap = $urandom_range(1, 10);
      end else begin
        step();
      end
      budget--;
    end
    check("rand_budget_ok", {31'b0, budget > 0}, 32'd1);
    check("rand_delivered", W'(n_out - out_mark), 32'd20);
    check("rand_sb_empty", W'(sb.size()), 32'd0);

    // Reset while a beat is stalled in the stage.
    mst_i_ready = 1'b0; slv_i_valid = 1'b1; slv_i_data = 32'h55;
    step();
    slv_i_valid = 1'b0;
    check("mid_fill_data", mst_o_data, 32'h55);
    #2;
    i_rstn = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, mst_o_valid}, 32'd0);
    check("mid_rst_data", mst_o_data, 32'd0);
    check("mid_rst_ready", {31'b0, slv_o_ready}, 32'd0);
    out_mark = n_out;
    mst_i_ready = 1'b1;
    step(); step();
    i_rstn = 1'b0;
    step(); step(); step();
    check("mid_no_55_valid", {31'b0, mst_o_valid}, 32'd0);
    check("mid_no_55_count", W'(n_out - out_mark), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
